// File: rtl/bram_arbiter.sv
// bram_arbiter: unpacks 64-bit loader words into four 16-bit BRAM
// writes and arbitrates the single BRAM port against PE index reads.
// Ports: clk/reset (sync, active-low); loader wr_valid/wr_data/wr_ready;
// PE rd_req/rd_addr/rd_gnt/rd_data_valid/rd_data/rd_err;
// BRAM bram_en/bram_we/bram_addr/bram_wdata/bram_rdata; stored/full.
module bram_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [63:0]       wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_data_valid,
  output logic [15:0]       rd_data,
  output logic              rd_err,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [15:0]       bram_wdata,
  input  logic [15:0]       bram_rdata,
  output logic [ADDR_W:0]   stored,
  output logic              full
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_UNPACK = 1'b1;
  localparam logic WIN_WR = 1'b0;
  localparam logic WIN_RD = 1'b1;
  localparam logic [ADDR_W:0] DEPTH =
    {1'b1, {ADDR_W{1'b0}}};

  logic [0:0]        state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   stored_q, stored_d;
  logic              last_win_q, last_win_d;
  logic [63:0]       word_q, word_d;
  logic              rvalid_q, rvalid_d;
  logic              rerr_q, rerr_d;
  logic              wr_ready_q, wr_ready_d;

  logic        wr_pend, rd_ok, rd_bad;
  logic        conflict, rd_win, wr_win;
  logic        wr_g, rd_g, err_g;
  logic [15:0] lane_word;

  assign lane_word = word_q[{lane_q, 4'b0000} +: 16];
  assign full      = (stored_q == DEPTH);

  // Reads at or beyond the fill level never touch the BRAM;
  // they are answered with an error and do not arbitrate.
  always_comb begin
    wr_pend  = (state_q == S_UNPACK);
    rd_ok    = rd_req && ({1'b0, rd_addr} < stored_q);
    rd_bad   = rd_req && !rd_ok;
    conflict = wr_pend && rd_ok;
    rd_win   = rd_ok &&
               (!wr_pend || last_win_q == WIN_WR);
    wr_win   = wr_pend && !rd_win;
    wr_g     = reset && wr_win;
    rd_g     = reset && rd_win;
    err_g    = reset && rd_bad;
    rd_gnt   = rd_g || err_g;
  end

  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    unique case (1'b1)
      wr_g: begin
        bram_en    = 1'b1;
        bram_we    = 1'b1;
        bram_addr  = wptr_q;
        bram_wdata = lane_word;
      end
      rd_g: begin
        bram_en   = 1'b1;
        bram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    wptr_d     = wptr_q;
    stored_d   = stored_q;
    last_win_d = last_win_q;
    word_d     = word_q;
    if (state_q == S_IDLE && wr_valid) begin
      state_d = S_UNPACK;
      lane_d  = 2'd0;
      word_d  = wr_data;
    end
    if (wr_g) begin
      wptr_d = wptr_q + 1'b1;
      lane_d = lane_q + 2'd1;
      if (!full) stored_d = stored_q + 1'b1;
      if (lane_q == 2'd3) state_d = S_IDLE;
    end
    if (conflict)
      last_win_d = rd_win ? WIN_RD : WIN_WR;
    rvalid_d   = rd_gnt;
    rerr_d     = err_g;
    wr_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lane_q     <= 2'd0;
      wptr_q     <= '0;
      stored_q   <= '0;
      last_win_q <= WIN_WR;
      word_q     <= '0;
      rvalid_q   <= 1'b0;
      rerr_q     <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      wptr_q     <= wptr_d;
      stored_q   <= stored_d;
      last_win_q <= last_win_d;
      word_q     <= word_d;
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign wr_ready      = wr_ready_q;
  assign rd_data_valid = rvalid_q;
  assign rd_err        = rerr_q;
  assign stored        = stored_q;
  assign rd_data = (rvalid_q && !rerr_q) ?
                   bram_rdata : 16'd0;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed bench for bram_arbiter, one wide
// (ADDR_W=8) and one tiny (ADDR_W=2) instance with BRAM models.
module tb_bram_arbiter;

  logic clk, reset;
  int n_pass, n_total;

  logic        wv8, wr8, rq8, gnt8, rdv8, rerr8;
  logic [63:0] wd8;
  logic [7:0]  ra8, ba8;
  logic [15:0] rdat8, bwd8, brd8;
  logic        ben8, bwe8, full8;
  logic [8:0]  st8;
  logic [15:0] mem8 [256];

  logic        wv2, wr2, rq2, gnt2, rdv2, rerr2;
  logic [63:0] wd2;
  logic [1:0]  ra2, ba2;
  logic [15:0] rdat2, bwd2, brd2;
  logic        ben2, bwe2, full2;
  logic [2:0]  st2;
  logic [15:0] mem2 [4];

  bram_arbiter #(.ADDR_W(8)) u8 (
    .clk(clk), .reset(reset),
    .wr_valid(wv8), .wr_data(wd8), .wr_ready(wr8),
    .rd_req(rq8), .rd_addr(ra8), .rd_gnt(gnt8),
    .rd_data_valid(rdv8), .rd_data(rdat8),
    .rd_err(rerr8), .bram_en(ben8), .bram_we(bwe8),
    .bram_addr(ba8), .bram_wdata(bwd8),
    .bram_rdata(brd8), .stored(st8), .full(full8)
  );

  bram_arbiter #(.ADDR_W(2)) u2 (
    .clk(clk), .reset(reset),
    .wr_valid(wv2), .wr_data(wd2), .wr_ready(wr2),
    .rd_req(rq2), .rd_addr(ra2), .rd_gnt(gnt2),
    .rd_data_valid(rdv2), .rd_data(rdat2),
    .rd_err(rerr2), .bram_en(ben2), .bram_we(bwe2),
    .bram_addr(ba2), .bram_wdata(bwd2),
    .bram_rdata(brd2), .stored(st2), .full(full2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ben8 && bwe8) mem8[ba8] <= bwd8;
    if (ben8 && !bwe8) brd8 <= mem8[ba8];
    if (ben2 && bwe2) mem2[ba2] <= bwd2;
    if (ben2 && !bwe2) brd2 <= mem2[ba2];
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rq8 = 1'b1;
    ra8 = 8'd5;
    @(negedge clk);
    #1;
    n_total++;
    if ({gnt8, ben8} !== 2'b00)
      $display("FAIL rst_gnt got %b want 00",
               {gnt8, ben8});
    else n_pass++;
    tick();
    rq8 = 1'b0;
    reset = 1'b1;
    tick();
    #1;
    n_total++;
    if ({wr8, rdv8, rerr8, full8, ben8} !== 5'b10000)
      $display("FAIL rst_flags got %b want 10000",
               {wr8, rdv8, rerr8, full8, ben8});
    else n_pass++;
    n_total++;
    if ({st8, rdat8} !== 25'd0)
      $display("FAIL rst_vals got %h/%h want 0/0",
               st8, rdat8);
    else n_pass++;
  endtask

  task automatic test_unpack;
    logic [41:0] got, exp;
    wv8 = 1'b1;
    wd8 = 64'h0004_0003_0002_0001;
    #1;
    n_total++;
    if (wr8 !== 1'b1)
      $display("FAIL unp_ready got %b want 1", wr8);
    else n_pass++;
    tick();
    wv8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      got = {wr8, ben8, bwe8, ba8, bwd8, 15'd0};
      exp = {1'b0, 1'b1, 1'b1, 8'(k),
             16'(k + 1), 15'd0};
      n_total++;
      if (got !== exp)
        $display("FAIL unp_lane%0d got %h want %h",
                 k, got, exp);
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if ({wr8, ben8, st8} !== {2'b10, 9'd4})
      $display("FAIL unp_done got %b/%0d want 1/0/4",
               {wr8, ben8}, st8);
    else n_pass++;
  endtask

  task automatic test_read;
    rq8 = 1'b1;
    ra8 = 8'd2;
    #1;
    n_total++;
    if ({gnt8, ben8, bwe8, ba8} !== {3'b110, 8'd2})
      $display("FAIL rd_gnt got %b/%0d want 110/2",
               {gnt8, ben8, bwe8}, ba8);
    else n_pass++;
    tick();
    rq8 = 1'b0;
    #1;
    n_total++;
    if ({rdv8, rerr8, rdat8} !== {2'b10, 16'd3})
      $display("FAIL rd_resp got %b/%h want 10/3",
               {rdv8, rerr8}, rdat8);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    rq8 = 1'b1;
    ra8 = 8'd0;
    #1;
    n_total++;
    if ({gnt8, ba8} !== {1'b1, 8'd0})
      $display("FAIL b2b_g0 got %b/%0d want 1/0",
               gnt8, ba8);
    else n_pass++;
    tick();
    ra8 = 8'd3;
    #1;
    n_total++;
    if ({gnt8, ba8, rdv8, rdat8} !==
        {1'b1, 8'd3, 1'b1, 16'd1})
      $display("FAIL b2b_g1 got %b/%0d/%b/%h want 1/3/1/1",
               gnt8, ba8, rdv8, rdat8);
    else n_pass++;
    tick();
    rq8 = 1'b0;
    #1;
    n_total++;
    if ({rdv8, rdat8} !== {1'b1, 16'd4})
      $display("FAIL b2b_r1 got %b/%h want 1/4",
               rdv8, rdat8);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (rdv8 !== 1'b0)
      $display("FAIL b2b_idle got %b want 0", rdv8);
    else n_pass++;
  endtask

  task automatic test_conflict;
    logic [26:0] got, exp;
    logic [16:0] rgot, rexp;
    wv8 = 1'b1;
    wd8 = 64'h0008_0007_0006_0005;
    tick();
    wv8 = 1'b0;
    rq8 = 1'b1;
    ra8 = 8'd0;
    for (int i = 0; i < 8; i++) begin
      #1;
      got = {gnt8, ben8, bwe8, ba8, bwd8};
      if (i % 2 == 0)
        exp = {3'b110, 8'd0, 16'd0};
      else
        exp = {3'b011, 8'(4 + i / 2),
               16'(5 + i / 2)};
      n_total++;
      if (got !== exp)
        $display("FAIL cfl_gnt%0d got %h want %h",
                 i, got, exp);
      else n_pass++;
      rgot = {rdv8, rdat8};
      rexp = (i % 2 == 1) ? {1'b1, 16'd1} : 17'd0;
      n_total++;
      if (rgot !== rexp)
        $display("FAIL cfl_resp%0d got %h want %h",
                 i, rgot, rexp);
      else n_pass++;
      tick();
    end
    rq8 = 1'b0;
    #1;
    n_total++;
    if ({wr8, st8} !== {1'b1, 9'd8})
      $display("FAIL cfl_done got %b/%0d want 1/8",
               wr8, st8);
    else n_pass++;
  endtask

  task automatic test_error;
    do_reset();
    wv8 = 1'b1;
    wd8 = 64'h000d_000c_000b_000a;
    tick();
    wv8 = 1'b0;
    tick();
    rq8 = 1'b1;
    ra8 = 8'd5;
    #1;
    n_total++;
    if ({gnt8, ben8, bwe8, ba8, bwd8} !==
        {3'b111, 8'd1, 16'h000b})
      $display("FAIL err_gnt got %b/%0d/%h want 111/1/b",
               {gnt8, ben8, bwe8}, ba8, bwd8);
    else n_pass++;
    tick();
    ra8 = 8'd2;
    #1;
    n_total++;
    if ({rdv8, rerr8, rdat8} !== {2'b11, 16'd0})
      $display("FAIL err_resp got %b/%h want 11/0",
               {rdv8, rerr8}, rdat8);
    else n_pass++;
    n_total++;
    if ({gnt8, bwe8, ba8} !== {2'b11, 8'd2})
      $display("FAIL err_same got %b/%0d want 11/2",
               {gnt8, bwe8}, ba8);
    else n_pass++;
    tick();
    rq8 = 1'b0;
    #1;
    n_total++;
    if ({rdv8, rerr8, rdat8} !== {2'b11, 16'd0})
      $display("FAIL err_same_resp got %b/%h want 11/0",
               {rdv8, rerr8}, rdat8);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if ({wr8, st8} !== {1'b1, 9'd4})
      $display("FAIL err_done got %b/%0d want 1/4",
               wr8, st8);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    wv8 = 1'b1;
    wd8 = 64'h0014_0013_0012_0011;
    tick();
    wv8 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_total++;
    if (ben8 !== 1'b0)
      $display("FAIL mid_en got %b want 0", ben8);
    else n_pass++;
    tick();
    reset = 1'b1;
    #1;
    n_total++;
    if ({wr8, ben8, st8} !== {2'b10, 9'd0})
      $display("FAIL mid_state got %b/%0d want 10/0",
               {wr8, ben8}, st8);
    else n_pass++;
    rq8 = 1'b1;
    ra8 = 8'd0;
    #1;
    n_total++;
    if ({gnt8, ben8} !== 2'b10)
      $display("FAIL mid_gnt got %b want 10",
               {gnt8, ben8});
    else n_pass++;
    tick();
    rq8 = 1'b0;
    #1;
    n_total++;
    if ({rdv8, rerr8} !== 2'b11)
      $display("FAIL mid_err got %b want 11",
               {rdv8, rerr8});
    else n_pass++;
  endtask

  task automatic test_wrap;
    logic [19:0] got, exp;
    wv2 = 1'b1;
    wd2 = 64'h0004_0003_0002_0001;
    tick();
    wv2 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #1;
    n_total++;
    if ({full2, st2} !== {1'b1, 3'd4})
      $display("FAIL wrap_full1 got %b/%0d want 1/4",
               full2, st2);
    else n_pass++;
    wv2 = 1'b1;
    wd2 = 64'h0008_0007_0006_0005;
    tick();
    wv2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      got = {ben2, bwe2, ba2, bwd2};
      exp = {2'b11, 2'(k), 16'(5 + k)};
      n_total++;
      if (got !== exp)
        $display("FAIL wrap_lane%0d got %h want %h",
                 k, got, exp);
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if ({full2, st2, wr2} !== {1'b1, 3'd4, 1'b1})
      $display("FAIL wrap_full2 got %b/%0d want 1/4",
               full2, st2);
    else n_pass++;
    rq2 = 1'b1;
    ra2 = 2'd0;
    #1;
    n_total++;
    if ({gnt2, ben2, bwe2} !== 3'b110)
      $display("FAIL wrap_gnt got %b want 110",
               {gnt2, ben2, bwe2});
    else n_pass++;
    tick();
    rq2 = 1'b0;
    #1;
    n_total++;
    if ({rdv2, rerr2, rdat2} !== {2'b10, 16'd5})
      $display("FAIL wrap_rd got %b/%h want 10/5",
               {rdv2, rerr2}, rdat2);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    wv8 = 1'b0; wd8 = '0; rq8 = 1'b0; ra8 = '0;
    wv2 = 1'b0; wd2 = '0; rq2 = 1'b0; ra2 = '0;
    brd8 = '0;
    brd2 = '0;
    test_reset();
    test_unpack();
    test_read();
    test_back_to_back();
    test_conflict();
    test_error();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Sequencer and arbiter for the single-port index BRAM in the sparse-matrix datapath. Accepts 64-bit packed index words from the memory loader and unpacks each into four 16-bit BRAM writes at an auto-incrementing write pointer. Also services single-index random reads from the multiplier PE, and shares the one BRAM port between the two with alternating priority. Sits between the memory-slot loader, the PE index fetch, and the bram primitive.

## Interface
- ADDR_W, 8, BRAM address width; depth = 2^ADDR_W entries of 16 bits
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- wr_valid  in  1  loader has a packed word on wr_data
- wr_data  in  64  four indices; lane k = wr_data[16k+15:16k], lane 0 written first
- wr_ready  out  1  block can accept a word this cycle
- rd_req  in  1  PE read request; held with rd_addr stable until rd_gnt
- rd_addr  in  ADDR_W  index address to read
- rd_gnt  out  1  read request accepted this cycle (combinational)
- rd_data_valid  out  1  response valid, one cycle after rd_gnt
- rd_data  out  16  read index (bram_rdata passthrough when valid and no error, else 0)
- rd_err  out  1  qualifies rd_data_valid: address was not yet written
- bram_en  out  1  BRAM port enable
- bram_we  out  1  1 = write, 0 = read
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  16  BRAM write data
- bram_rdata  in  16  BRAM read data, synchronous, 1-cycle latency
- stored  out  ADDR_W+1  number of entries written, saturates at 2^ADDR_W
- full  out  1  stored == 2^ADDR_W

## Operation
- Write FSM states: IDLE, UNPACK. wr_ready = (state == IDLE).
- IDLE: wr_valid && wr_ready → latch wr_data, lane = 0, go to UNPACK.
- UNPACK: write pending every cycle. On write grant: bram_en = 1, bram_we = 1, bram_addr = wptr, bram_wdata = latched lane; wptr++, lane++, stored++ (saturating).
- UNPACK exit: grant with lane == 3 → IDLE. A new word can be accepted on the following cycle at the earliest.
- wptr wraps from 2^ADDR_W-1 to 0 and overwrites the oldest entry. stored stays at 2^ADDR_W and full stays high.
- Read valid iff rd_addr < stored; otherwise it is an error read.
- Error read: rd_gnt asserted immediately regardless of write activity. No BRAM access, not counted by arbitration. The write (if pending) proceeds the same cycle. Next cycle rd_data_valid = 1, rd_err = 1, rd_data = 0.
- Valid read alone: granted; bram_en = 1, bram_we = 0, bram_addr = rd_addr.
- Write alone: granted.
- Valid read and write pending in the same cycle: grant the requester not granted in the last conflict. Register last_win updates only on conflict cycles.
- last_win resets to WRITE, so the read wins the first conflict.
- stored compares against the count before the current cycle's write. A read of the address being written in the same cycle is an error read.
- No grant → bram_en = 0, bram_we = 0, bram_addr = 0, bram_wdata = 0.

## Timing
- Reset (reset == 0 at edge), applied to all registers:
  - state = IDLE, lane = 0, wptr = 0, stored = 0, last_win = WRITE.
  - Latched word discarded, pending response cleared.
  - Outputs: wr_ready = 1 after reset, rd_gnt = 0 while reset low, rd_data_valid = 0, rd_err = 0, rd_data = 0, full = 0, bram_en = 0.
- Reset mid-UNPACK abandons remaining lanes. Lanes already written stay in the BRAM but are uncounted.
- Reset asserted the cycle after a grant suppresses that response.
- Unpack latency without conflict: accept at cycle T, lane writes at T+1..T+4, wr_ready high again at T+5. Sustained throughput is 4 indices per 5 cycles.
- Under continuous valid reads, writes and reads alternate: lane writes occur every other cycle, and the word takes 8 cycles.
- Read latency: grant at T → rd_data_valid at T+1 with rd_data = bram_rdata. Back-to-back grants produce back-to-back responses.
- The rd_gnt and bram_* outputs are combinational from state, rd_req, rd_addr, stored, last_win. wr_ready, rd_data_valid, rd_err are registered.

## Test plan
- **Unpack:** wr_data = 0x0004_0003_0002_0001 at cycle 0 → writes (addr, data) = (0,1), (1,2), (2,3), (3,4) at cycles 1–4; wr_ready low at cycles 1–4; stored = 4.
- **Read after fill:** rd_req at addr 2 → rd_gnt same cycle, bram_addr = 2 with we = 0. Next cycle rd_data_valid = 1, rd_err = 0, rd_data = 3.
- **Conflict:** word accepted, then rd_req addr 0 held continuously.
  - Grants: read first, then write lane 0, read, lane 1, and so on, alternating.
  - The word completes 8 cycles after acceptance.
- **Error read:** stored = 1, rd_req addr 5 during UNPACK → rd_gnt immediately; the lane write proceeds the same cycle. Next cycle rd_err = 1, rd_data = 0.
- **Wrap:** ADDR_W = 2, two words 0x...0001–0004 then 0x...0005–0008.
  - After the first word: full = 1, stored = 4.
  - The second word writes addresses 0–3 again.
  - A read of addr 0 returns 5.
- **Reset mid-unpack:** reset low one cycle after lane 1 written → next cycle state IDLE, stored = 0, wr_ready = 1, no BRAM access. A read of addr 0 returns rd_err = 1.
